// File: rtl/aes_in_word_loader_pkg.sv
// Shared definitions for the AES input word loader.
// - state_t : loader FSM states (plaintext load, key load, full/holding)
// - WORD_W  : width of one input stream word
package aes_in_word_loader_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    LOAD_PT  = 2'd0,
    LOAD_KEY = 2'd1,
    FULL     = 2'd2
  } state_t;

endpackage

// File: rtl/aes_in_word_loader_if.sv
// Word-stream input and block-output handshake bundle of the AES input loader.
// - in_word_valid/in_word_ready/in_word : 32-bit word stream (PT words, then KEY words)
// - out_valid/out_ready                 : one full plaintext+key transfer
// - out_shares_plaintext/out_shares_key : 128*D bits each, share i at [128*i +: 128]
// - busy                                : a block is partially loaded
// master = word producer / block consumer side, slave = loader side.
interface aes_in_word_loader_if #(parameter int D = 2);
  import aes_in_word_loader_pkg::*;

  logic              in_word_valid;
  logic              in_word_ready;
  logic [WORD_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [128*D-1:0]  out_shares_plaintext;
  logic [128*D-1:0]  out_shares_key;
  logic              busy;

  modport master (
    output in_word_valid, in_word, out_ready,
    input  in_word_ready, out_valid, out_shares_plaintext, out_shares_key, busy
  );

  modport slave (
    input  in_word_valid, in_word, out_ready,
    output in_word_ready, out_valid, out_shares_plaintext, out_shares_key, busy
  );

endinterface

// File: rtl/aes_in_word_loader_word_shift_reg.sv
// Word-granular shift register for one loader operand.
// - clk, rst_n : clock, synchronous active-low clear to zero
// - shift_en   : push din in at the top, everything moves down by W bits
// - din        : incoming word
// - q          : register contents; after WIDTH/W pushes the first word sits at the LSBs
module word_shift_reg #(
  parameter int WIDTH = 256,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic [W-1:0]     din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)        q <= '0;
    else if (shift_en) q <= {din, q[WIDTH-1:W]};
  end

endmodule

// File: rtl/aes_in_word_loader.sv
// Collects a shared plaintext and shared key from a 32-bit word stream and
// presents them together as one transfer to the masked AES top.
// - clk, rst_n : clock, synchronous active-low reset
// - bus        : slave side of aes_in_word_loader_if (word stream in, block out, busy)
// Per block: 4*d plaintext words then 4*d key words, LSW of share 0 first.
// Output registers are not cleared after a handshake; the next block simply
// shifts over the stale contents.
module aes_in_word_loader
  import aes_in_word_loader_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_in_word_loader_if.slave   bus
);

  localparam int NWORDS = 4 * d;
  localparam int CW     = $clog2(NWORDS);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rdy;
  logic            ov;
  logic            accept;
  logic            last;
  logic [128*d-1:0] pt_q;
  logic [128*d-1:0] key_q;

  // rdy is only ever high in the two load states, so it alone qualifies an accept.
  assign accept = bus.in_word_valid & rdy;
  assign last   = (cnt == CW'(NWORDS - 1));

  word_shift_reg #(.WIDTH(128*d), .W(WORD_W)) u_pt (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept & (state == LOAD_PT)),
    .din      (bus.in_word),
    .q        (pt_q)
  );

  word_shift_reg #(.WIDTH(128*d), .W(WORD_W)) u_key (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept & (state == LOAD_KEY)),
    .din      (bus.in_word),
    .q        (key_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD_PT;
      cnt   <= '0;
      rdy   <= 1'b0;
      ov    <= 1'b0;
    end else begin
      case (state)
        LOAD_PT, LOAD_KEY: begin
          rdy <= 1'b1;  // also raises ready on the first cycle out of reset
          if (accept) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
              if (state == LOAD_PT) begin
                state <= LOAD_KEY;
              end else begin
                state <= FULL;
                rdy   <= 1'b0;
                ov    <= 1'b1;
              end
            end
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            state <= LOAD_PT;
            ov    <= 1'b0;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= LOAD_PT;
          cnt   <= '0;
          rdy   <= 1'b0;
          ov    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_word_ready        = rdy;
  assign bus.out_valid            = ov;
  assign bus.out_shares_plaintext = pt_q;
  assign bus.out_shares_key       = key_q;
  assign bus.busy                 = (state == LOAD_KEY) | ((state == LOAD_PT) & (cnt != '0));

endmodule

// File: tb/tb_aes_in_word_loader.sv
module tb_aes_in_word_loader;
  import aes_in_word_loader_pkg::*;

  localparam int D  = 2;
  localparam int NW = 4 * D;
  localparam int BW = 128 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst3_n = 1'b0;
  always #5 clk = ~clk;

  aes_in_word_loader_if #(.D(D)) bus ();
  aes_in_word_loader_if #(.D(3)) bus3 ();

  aes_in_word_loader #(.d(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  aes_in_word_loader #(.d(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (d=2 instance) ----------------
  // Tracks only "how many words of this block have been taken" and "is a
  // full block waiting"; the expected buses are rebuilt from the word list.
  bit          m_rdy = 1'b0;
  bit          m_full = 1'b0;
  int          m_k = 0;
  logic [31:0] m_w [2*NW];
  int          cyc = 0;
  int          acc_cyc [$];
  logic [BW-1:0] ept, ekey;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_rdy = 1'b0; m_full = 1'b0; m_k = 0;
    end else if (m_full) begin
      if (bus.out_ready) begin m_full = 1'b0; m_rdy = 1'b1; end
    end else begin
      if (m_rdy && bus.in_word_valid) begin
        m_w[m_k] = bus.in_word;
        m_k++;
        acc_cyc.push_back(cyc);
        if (m_k == 2*NW) begin m_full = 1'b1; m_k = 0; end
      end
      m_rdy = !m_full;
    end
  end

  always @(negedge clk) begin
    chk("in_word_ready", bus.in_word_ready, m_rdy);
    chk("out_valid", bus.out_valid, m_full);
    chk("busy", bus.busy, !m_full && m_k != 0);
    if (m_full) begin
      for (int n = 0; n < NW; n++) begin
        ept[32*n +: 32]  = m_w[n];
        ekey[32*n +: 32] = m_w[NW+n];
      end
      chk("pt_bus", bus.out_shares_plaintext, ept);
      chk("key_bus", bus.out_shares_key, ekey);
    end
  end

  // Random out_ready while enabled.
  bit rand_or = 1'b0;
  always @(posedge clk) begin
    if (rand_or) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present one word after 'idle' empty cycles and hold it until accepted.
  task automatic put_word(input logic [31:0] w, input int idle);
    logic acc;
    acc = 1'b0;
    bus.in_word_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    bus.in_word_valid = 1'b1;
    bus.in_word = w;
    for (int t = 0; t < 200; t++) begin
      acc = bus.in_word_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: word %0h never accepted", w);
    end
    bus.in_word_valid = 1'b0;
  endtask

  task automatic wait_idle_out();
    for (int t = 0; t < 200 && bus.out_valid; t++) begin @(posedge clk); #1; end
    if (bus.out_valid) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: out_valid still %0d", bus.out_valid);
    end
  endtask

  initial begin
    bus.in_word_valid = 1'b0; bus.in_word = '0; bus.out_ready = 1'b1;
    bus3.in_word_valid = 1'b0; bus3.in_word = '0; bus3.out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_ready", bus.in_word_ready, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pt", bus.out_shares_plaintext, '0);
    chk("rst_key", bus.out_shares_key, '0);
    rst_n = 1'b1;
    chk("ready_first_cycle", bus.in_word_ready, 1'b0);

    // 1: sixteen words back to back
    for (int i = 0; i < 2*NW; i++) put_word(32'(i), 0);
    chk("s1_valid", bus.out_valid, 1'b1);
    chk("s1_pt_lo", bus.out_shares_plaintext[31:0], 32'h0);
    chk("s1_pt_hi", bus.out_shares_plaintext[255:224], 32'h7);
    chk("s1_key_lo", bus.out_shares_key[31:0], 32'h8);
    chk("s1_key_hi", bus.out_shares_key[255:224], 32'hF);
    @(posedge clk); #1;
    chk("s1_valid_one_cycle", bus.out_valid, 1'b0);

    // 2: downstream stalls 10 cycles with an extra word waiting
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2*NW; i++) put_word(32'(i), 0);
    bus.in_word_valid = 1'b1; bus.in_word = 32'hDEAD_BEEF;
    repeat (10) begin @(posedge clk); #1; end
    chk("s2_valid_held", bus.out_valid, 1'b1);
    chk("s2_ready_low", bus.in_word_ready, 1'b0);
    chk("s2_pt_hi", bus.out_shares_plaintext[255:224], 32'h7);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_word_valid = 1'b0;
    chk("s2_ready_back", bus.in_word_ready, 1'b1);

    // 3: valid toggles every cycle
    for (int i = 0; i < 2*NW; i++) put_word(32'(i), (i == 0) ? 0 : 1);
    chk("s3_pt_lo", bus.out_shares_plaintext[31:0], 32'h0);
    chk("s3_pt_hi", bus.out_shares_plaintext[255:224], 32'h7);
    chk("s3_key_lo", bus.out_shares_key[31:0], 32'h8);
    chk("s3_key_hi", bus.out_shares_key[255:224], 32'hF);
    @(posedge clk); #1;

    // 4: reset after five plaintext words
    for (int i = 0; i < 5; i++) put_word(32'h50 + 32'(i), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("s4_busy", bus.busy, 1'b0);
    chk("s4_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 2*NW; i++) put_word(32'hA0 + 32'(i), 0);
    chk("s4_pt_lo", bus.out_shares_plaintext[31:0], 32'hA0);
    chk("s4_key_hi", bus.out_shares_key[255:224], 32'hAF);
    @(posedge clk); #1;

    // 5: two blocks with continuous valid
    acc_cyc.delete();
    for (int i = 0; i < 4*NW; i++) put_word(32'h1000 + 32'(i), 0);
    chk("s5_inblock_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    chk("s5_block_gap", 32'(acc_cyc[2*NW] - acc_cyc[2*NW-1]), 32'd2);
    chk("s5_pt_lo", bus.out_shares_plaintext[31:0], 32'h1010);
    @(posedge clk); #1;

    // Random traffic, random idles and random downstream backpressure
    rand_or = 1'b1;
    for (int b = 0; b < 6; b++)
      for (int i = 0; i < 2*NW; i++) put_word($urandom, $urandom_range(0, 2));
    rand_or = 1'b0;
    #1 bus.out_ready = 1'b1;
    @(posedge clk); #1;
    wait_idle_out();

    // d=3 instance: 24 words
    rst3_n = 1'b1;
    @(posedge clk); #1;
    chk("d3_busy_idle", bus3.busy, 1'b0);
    for (int i = 0; i < 24; i++) begin
      logic acc;
      acc = 1'b0;
      bus3.in_word_valid = 1'b1;
      bus3.in_word = 32'h300 + 32'(i);
      for (int t = 0; t < 200; t++) begin
        acc = bus3.in_word_ready;
        @(posedge clk); #1;
        if (acc) break;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL d3_accept_timeout: word %0d", i);
      end
      bus3.in_word_valid = 1'b0;
      chk("d3_busy", bus3.busy, (i < 23));
    end
    chk("d3_valid", bus3.out_valid, 1'b1);
    chk("d3_pt_hi", bus3.out_shares_plaintext[383:352], 32'h30B);
    chk("d3_key_lo", bus3.out_shares_key[31:0], 32'h30C);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
